// File: rtl/nx_stream_distributor_pkg.sv
// Shared message/direction types for the nx mesh node, plus the source
// selector used by the outbound distributor's round-robin.
`timescale 1ns/1ps
package nx_stream_distributor_pkg;

    localparam int NX_MSG_W    = 16;
    localparam int NX_NUM_DIRS = 4;

    typedef logic [NX_MSG_W-1:0] nx_message_t;

    typedef enum logic [1:0] {
        NX_NORTH = 2'd0,
        NX_EAST  = 2'd1,
        NX_SOUTH = 2'd2,
        NX_WEST  = 2'd3
    } nx_direction_t;

    typedef enum logic {
        NX_SRC_BYPASS = 1'b0,
        NX_SRC_EMIT   = 1'b1
    } nx_src_t;

endpackage

// File: rtl/nx_stream_fifo.sv
// Small FIFO feeding one neighbour link. The head reads as zero while the
// FIFO is empty.
`timescale 1ns/1ps
module nx_stream_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == CNT_W'(DEPTH));
    assign empty_o = (count == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = empty_o ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; emptiness alone gates what the head shows.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/nx_stream_distributor.sv
// Merges the arbiter bypass stream and the node emit stream round-robin into
// four per-direction output FIFOs driving the neighbour links.
`timescale 1ns/1ps
module nx_stream_distributor
    import nx_stream_distributor_pkg::*;
#(
    parameter int OUT_DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  nx_message_t   bypass_data_i,
    input  nx_direction_t bypass_dir_i,
    input  logic          bypass_valid_i,
    output logic          bypass_ready_o,
    input  nx_message_t   emit_data_i,
    input  nx_direction_t emit_dir_i,
    input  logic          emit_valid_i,
    output logic          emit_ready_o,
    output nx_message_t   north_data_o,
    output nx_message_t   east_data_o,
    output nx_message_t   south_data_o,
    output nx_message_t   west_data_o,
    output logic          north_valid_o,
    output logic          east_valid_o,
    output logic          south_valid_o,
    output logic          west_valid_o,
    input  logic          north_ready_i,
    input  logic          east_ready_i,
    input  logic          south_ready_i,
    input  logic          west_ready_i,
    output logic          idle_o
);

    nx_src_t                prefer;
    logic                   bypass_elig;
    logic                   emit_elig;
    logic                   grant_bypass;
    logic                   grant_emit;
    nx_message_t            push_data;
    logic [NX_NUM_DIRS-1:0] push_vec;
    logic [NX_NUM_DIRS-1:0] pop_vec;
    logic [NX_NUM_DIRS-1:0] full;
    logic [NX_NUM_DIRS-1:0] empty;
    nx_message_t            head [NX_NUM_DIRS];

    // Eligibility looks only at FIFO fullness, never at the neighbours' ready.
    assign bypass_elig  = bypass_valid_i && !full[bypass_dir_i];
    assign emit_elig    = emit_valid_i && !full[emit_dir_i];
    assign grant_bypass = bypass_elig && (!emit_elig || prefer == NX_SRC_BYPASS);
    assign grant_emit   = emit_elig && (!bypass_elig || prefer == NX_SRC_EMIT);

    assign bypass_ready_o = grant_bypass;
    assign emit_ready_o   = grant_emit;

    always_comb begin
        push_vec  = '0;
        push_data = grant_bypass ? bypass_data_i : emit_data_i;
        if (grant_bypass)    push_vec[bypass_dir_i] = 1'b1;
        else if (grant_emit) push_vec[emit_dir_i]   = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)           prefer <= NX_SRC_BYPASS;
        else if (grant_bypass) prefer <= NX_SRC_EMIT;
        else if (grant_emit)   prefer <= NX_SRC_BYPASS;
    end

    assign pop_vec = {west_ready_i, south_ready_i, east_ready_i, north_ready_i} & ~empty;

    for (genvar g = 0; g < NX_NUM_DIRS; g++) begin : g_dir
        nx_stream_fifo #(
            .WIDTH (NX_MSG_W),
            .DEPTH (OUT_DEPTH)
        ) u_fifo (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .push_i      (push_vec[g]),
            .push_data_i (push_data),
            .pop_i       (pop_vec[g]),
            .full_o      (full[g]),
            .empty_o     (empty[g]),
            .head_o      (head[g])
        );
    end

    assign north_data_o  = head[NX_NORTH];
    assign east_data_o   = head[NX_EAST];
    assign south_data_o  = head[NX_SOUTH];
    assign west_data_o   = head[NX_WEST];
    assign north_valid_o = !empty[NX_NORTH];
    assign east_valid_o  = !empty[NX_EAST];
    assign south_valid_o = !empty[NX_SOUTH];
    assign west_valid_o  = !empty[NX_WEST];

    assign idle_o = (&empty) && !bypass_valid_i && !emit_valid_i;

endmodule

// File: tb/tb_nx_stream_distributor.sv
// Bench for nx_stream_distributor: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_nx_stream_distributor;
    import nx_stream_distributor_pkg::*;

    localparam int OUT_DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    nx_message_t   bypass_data = '0;
    nx_direction_t bypass_dir = NX_NORTH;
    logic          bypass_valid = 1'b0;
    logic          bypass_ready;
    nx_message_t   emit_data = '0;
    nx_direction_t emit_dir = NX_NORTH;
    logic          emit_valid = 1'b0;
    logic          emit_ready;
    nx_message_t   odata [4];
    logic [3:0]    ovalid;
    logic [3:0]    oready = 4'b0000;
    logic          idle;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nx_stream_distributor #(.OUT_DEPTH(OUT_DEPTH)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .bypass_data_i  (bypass_data),
        .bypass_dir_i   (bypass_dir),
        .bypass_valid_i (bypass_valid),
        .bypass_ready_o (bypass_ready),
        .emit_data_i    (emit_data),
        .emit_dir_i     (emit_dir),
        .emit_valid_i   (emit_valid),
        .emit_ready_o   (emit_ready),
        .north_data_o   (odata[0]),
        .east_data_o    (odata[1]),
        .south_data_o   (odata[2]),
        .west_data_o    (odata[3]),
        .north_valid_o  (ovalid[0]),
        .east_valid_o   (ovalid[1]),
        .south_valid_o  (ovalid[2]),
        .west_valid_o   (ovalid[3]),
        .north_ready_i  (oready[0]),
        .east_ready_i   (oready[1]),
        .south_ready_i  (oready[2]),
        .west_ready_i   (oready[3]),
        .idle_o         (idle)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one bounded queue per direction and a preferred source.
    nx_message_t mq [4][$];
    logic        m_prefer_emit = 1'b0;

    function automatic void model_grant(output logic gb, output logic ge);
        logic be, ee;
        be = bypass_valid && (mq[bypass_dir].size() < OUT_DEPTH);
        ee = emit_valid && (mq[emit_dir].size() < OUT_DEPTH);
        if (be && ee) begin
            gb = !m_prefer_emit;
            ge = m_prefer_emit;
        end else begin
            gb = be;
            ge = ee;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic gb, ge;
        if (!rst_n) begin
            for (int d = 0; d < 4; d++) mq[d].delete();
            m_prefer_emit = 1'b0;
        end else begin
            model_grant(gb, ge);
            for (int d = 0; d < 4; d++)
                if (mq[d].size() > 0 && oready[d]) void'(mq[d].pop_front());
            if (gb) begin
                mq[bypass_dir].push_back(bypass_data);
                m_prefer_emit = 1'b1;
            end else if (ge) begin
                mq[emit_dir].push_back(emit_data);
                m_prefer_emit = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic gb, ge, all_empty;
        model_grant(gb, ge);
        check("bypass_ready", bypass_ready, gb);
        check("emit_ready", emit_ready, ge);
        all_empty = 1'b1;
        for (int d = 0; d < 4; d++) begin
            check($sformatf("valid[%0d]", d), ovalid[d], mq[d].size() > 0);
            check($sformatf("data[%0d]", d), odata[d], (mq[d].size() > 0) ? mq[d][0] : '0);
            if (mq[d].size() > 0) all_empty = 1'b0;
        end
        check("idle", idle, all_empty && !bypass_valid && !emit_valid);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nb, ne;
        logic exp_b;
        nx_message_t last;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("lit_rst_idle", idle, 1'b1);
        check("lit_rst_valid", ovalid, 4'b0000);
        check("lit_rst_north_data", odata[0], 16'h0000);
        check("lit_rst_bready", bypass_ready, 1'b0);
        rst_n = 1'b1;
        tick();

        // Fairness: both sources contend for NORTH
        oready[0] = 1'b1;
        bypass_dir = NX_NORTH; emit_dir = NX_NORTH;
        bypass_valid = 1'b1; emit_valid = 1'b1;
        nb = 0; ne = 0; last = '0;
        for (int k = 0; k < 6; k++) begin
            bypass_data = nx_message_t'(16'hB000 + nb);
            emit_data   = nx_message_t'(16'hE000 + ne);
            #1;
            exp_b = (k % 2 == 0);
            check("lit_fair_bready", bypass_ready, exp_b);
            check("lit_fair_eready", emit_ready, !exp_b);
            if (k > 0) begin
                check("lit_fair_nvalid", ovalid[0], 1'b1);
                check("lit_fair_ndata", odata[0], last);
            end
            last = exp_b ? bypass_data : emit_data;
            if (exp_b) nb++; else ne++;
            tick();
        end
        bypass_valid = 1'b0; emit_valid = 1'b0;
        #1;
        check("lit_fair_last", odata[0], 16'hE002);
        tick();
        check("lit_fair_drained", ovalid[0], 1'b0);

        // Single path to SOUTH
        oready[2] = 1'b1;
        bypass_data = 16'hA001; bypass_dir = NX_SOUTH; bypass_valid = 1'b1;
        #1;
        check("lit_single_bready", bypass_ready, 1'b1);
        tick();
        bypass_valid = 1'b0;
        check("lit_single_svalid", ovalid[2], 1'b1);
        check("lit_single_sdata", odata[2], 16'hA001);
        tick();
        check("lit_single_sgone", ovalid[2], 1'b0);

        // Backpressure on WEST
        oready[3] = 1'b0;
        bypass_dir = NX_WEST; bypass_valid = 1'b1;
        bypass_data = 16'hC000; #1; check("lit_bp_acc0", bypass_ready, 1'b1); tick();
        bypass_data = 16'hC001; #1; check("lit_bp_acc1", bypass_ready, 1'b1); tick();
        bypass_data = 16'hC002; #1; check("lit_bp_stall", bypass_ready, 1'b0); tick();
        check("lit_bp_stall2", bypass_ready, 1'b0);
        check("lit_bp_head", odata[3], 16'hC000);
        oready[3] = 1'b1;
        #1;
        check("lit_bp_no_passthru", bypass_ready, 1'b0);
        tick();
        check("lit_bp_acc2", bypass_ready, 1'b1);
        check("lit_bp_head1", odata[3], 16'hC001);
        tick();
        bypass_valid = 1'b0;
        check("lit_bp_head2", odata[3], 16'hC002);
        tick();
        check("lit_bp_empty", ovalid[3], 1'b0);

        // Work-conserving: NORTH full, prefer back on BYPASS
        oready[0] = 1'b0; oready[1] = 1'b0;
        emit_dir = NX_NORTH; emit_valid = 1'b1;
        emit_data = 16'hD000; tick();
        emit_data = 16'hD001; tick();
        bypass_dir = NX_NORTH; bypass_data = 16'hF000; bypass_valid = 1'b1;
        emit_dir = NX_EAST; emit_data = 16'hD002;
        #1;
        check("lit_wc_eready", emit_ready, 1'b1);
        check("lit_wc_bready", bypass_ready, 1'b0);
        tick();
        bypass_dir = NX_EAST; emit_data = 16'hD003;
        #1;
        check("lit_wc_prefer_b", bypass_ready, 1'b1);
        check("lit_wc_prefer_e", emit_ready, 1'b0);
        tick();
        bypass_valid = 1'b0; emit_valid = 1'b0;
        check("lit_wc_east_head", odata[1], 16'hD002);
        oready[0] = 1'b1; oready[1] = 1'b1;
        repeat (3) tick();

        // Simultaneous push/pop on EAST
        oready[1] = 1'b0;
        emit_dir = NX_EAST; emit_data = 16'h6000; emit_valid = 1'b1;
        tick();
        emit_data = 16'h6001; oready[1] = 1'b1;
        #1;
        check("lit_pp_eready", emit_ready, 1'b1);
        check("lit_pp_head0", odata[1], 16'h6000);
        tick();
        emit_valid = 1'b0;
        check("lit_pp_valid", ovalid[1], 1'b1);
        check("lit_pp_head1", odata[1], 16'h6001);
        tick();
        check("lit_pp_empty", ovalid[1], 1'b0);

        // Asynchronous reset with EAST holding two messages
        oready[1] = 1'b0;
        emit_valid = 1'b1;
        emit_data = 16'h7000; tick();
        emit_data = 16'h7001; tick();
        emit_valid = 1'b0;
        #1;
        check("lit_rst_pre", ovalid[1], 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("lit_rst_async_valid", ovalid[1], 1'b0);
        check("lit_rst_async_idle", idle, 1'b1);
        tick();
        rst_n = 1'b1;
        #1;
        check("lit_rst_release_idle", idle, 1'b1);
        oready[0] = 1'b1;
        bypass_dir = NX_NORTH; emit_dir = NX_NORTH;
        bypass_data = 16'h8000; emit_data = 16'h8001;
        bypass_valid = 1'b1; emit_valid = 1'b1;
        #1;
        check("lit_rst_prefer_b", bypass_ready, 1'b1);
        check("lit_rst_prefer_e", emit_ready, 1'b0);
        tick();
        bypass_valid = 1'b0; emit_valid = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
